fifo_rd_stream: RTL and testbench
=================================

# fifo_rd_stream

Read-domain egress adapter for the async FIFO. Sits downstream of the read-pointer handler and FIFO memory in the `clk_r` domain. It issues `r_en` and captures the memory's registered read data into a 3-entry output buffer, presenting a valid/ready stream to the consumer. It also reports a registered fill level and an almost-empty flag derived from the synchronized Gray write pointer.

## Interface
- `DATA_WIDTH`, 8, width of FIFO words and `m_data`
- `PTR_WIDTH`, 3, FIFO address width; pointers are `PTR_WIDTH+1` bits
- `AEMPTY_THRESH`, 1, `almost_empty` asserts when level ≤ this value
- `clk_r`  in  1  read-domain clock
- `arst`  in  1  reset, synchronous, active-high
- `empty`  in  1  registered empty flag from the read-pointer handler
- `g_wptr_sync`  in  PTR_WIDTH+1  Gray write pointer, already synchronized to `clk_r`
- `b_rptr`  in  PTR_WIDTH+1  binary read pointer from the read-pointer handler
- `r_en`  out  1  read request to the pointer handler and memory
- `r_data`  in  DATA_WIDTH  memory read data, valid the cycle after an accepted read
- `m_valid`  out  1  stream word available
- `m_ready`  in  1  consumer accepts the word
- `m_data`  out  DATA_WIDTH  stream word (head of buffer)
- `rd_level`  out  PTR_WIDTH+1  registered FIFO occupancy seen by the read domain
- `almost_empty`  out  1  registered, `rd_level <= AEMPTY_THRESH`
- `rd_count`  out  16  accepted-word counter (see Configuration)

## Operation
- **Accepted read:** `r_en && !empty` in cycle T. `r_data` is sampled at the end of T+1 and pushed into the buffer. `inflight` is a 1-bit register marking a read issued last cycle.
- **Credit rule:** `r_en = !arst && !empty && (occ + inflight) < 3`.
  - `occ` is the buffer occupancy, 0..3, stored in a 2-bit register.
  - `r_en` is combinational from registers only. It has no path from `m_ready`.
- **Buffer:**
  - 3-entry circular FIFO with 2-bit head and tail indices that wrap 2→0.
  - `m_valid = (occ != 0)`. `m_data` is the head entry.
  - A pop occurs on `m_valid && m_ready`.
  - Push and pop in the same cycle: `occ` unchanged, both indices advance.
  - Push when `occ == 3` can never occur; the credit rule guarantees this. The bench asserts it.
- **Level:**
  - Convert `g_wptr_sync` Gray→binary with prefix XOR from the MSB.
  - `rd_level <= bin_wptr - b_rptr`, modulo 2^(PTR_WIDTH+1). This handles wrap-around.
  - Maximum value is 2^PTR_WIDTH (full).
- **`almost_empty`:** registered from the same-cycle level computation, not from the registered `rd_level`.
- **Reset (`arst`=1 at a clock edge):**
  - `occ`, indices and `inflight` are cleared. A pending in-flight word is discarded.
  - `rd_level`=0, `almost_empty`=1, `rd_count`=0.
  - While `arst` is high: `r_en`=0, `m_valid`=0.
  - Reset mid-stream drops all buffered words.

## Timing
- **Reset values:** `r_en`=0, `m_valid`=0, `m_data`=0 (buffer cleared), `rd_level`=0, `almost_empty`=1, `rd_count`=0.
- **First word:** `empty` falls in cycle N. `r_en`=1 in N, `r_data` is valid in N+1, `m_valid`=1 in N+2. Latency from `r_en` to `m_valid` is 2 cycles.
- **Throughput:** with `m_ready` held high and the FIFO non-empty, one word per cycle is sustained (steady state `occ`=1, `inflight`=1).
- **Backpressure:** with `m_ready`=0, at most 3 words are read before `r_en` deasserts. `r_en` resumes the cycle after the first pop lowers `occ + inflight` below 3.
- **Level latency:** `rd_level` and `almost_empty` lag `g_wptr_sync`/`b_rptr` by 1 cycle.

## Configuration
- **`FIFO_RD_STREAM_CNT_EN` defined:**
  - `rd_count` is a 16-bit register incremented on each `m_valid && m_ready`.
  - It wraps 0xFFFF→0x0000 and resets to 0.
- **Not defined:** `rd_count` is tied to 0 and no counter logic is built. The port list is identical in both builds.

## Test plan
- **Reset then idle:** `arst` for 2 cycles, `empty`=1 → `r_en`=0, `m_valid`=0, `rd_level`=0, `almost_empty`=1.
- **Single word:** write 0xA5 (`empty` falls at N), `m_ready`=1 → `r_en`=1 at N only; `m_valid`=1 with `m_data`=0xA5 at N+2 for one cycle.
- **Streaming:** 8 words 0x00..0x07, `m_ready`=1 → consecutive `m_valid` for 8 cycles, data in order, no gaps after the first.
- **Backpressure:** 6 words, `m_ready`=0 → exactly 3 `r_en` pulses. Then `m_ready`=1 → remaining 3 read, all 6 delivered in order, no overflow assertion.
- **Level wrap-around:** `b_rptr`=4'b1110, `g_wptr_sync`=Gray(4'b0010)=4'b0011 → `rd_level`=4 next cycle, `almost_empty`=0. With `b_rptr`=4'b0001 and the same `g_wptr_sync` → `rd_level`=1, `almost_empty`=1.
- **Reset mid-stream:** `arst` with `occ`=2 and `inflight`=1 → next cycle `m_valid`=0, `rd_count`=0. Post-reset words are delivered without any stale data.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Read-domain egress adapter: credit-gated r_en into a 3-entry skid buffer, plus registered fill level.
// Optional accepted-word counter is built when FIFO_RD_STREAM_CNT_EN is defined.
module fifo_rd_stream #(
  parameter int DATA_WIDTH    = 8,
  parameter int PTR_WIDTH     = 3,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  clk_r,
  input  logic                  arst,
  input  logic                  empty,
  input  logic [PTR_WIDTH:0]    g_wptr_sync,
  input  logic [PTR_WIDTH:0]    b_rptr,
  output logic                  r_en,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [PTR_WIDTH:0]    rd_level,
  output logic                  almost_empty,
  output logic [15:0]           rd_count
);

  localparam logic [PTR_WIDTH:0] AE_TH = AEMPTY_THRESH[PTR_WIDTH:0];

  logic [1:0]                  occ, head, tail;
  logic                        inflight;
  logic [2:0][DATA_WIDTH-1:0]  buf_q;
  logic                        push, pop;
  logic [PTR_WIDTH:0]          bin_wptr, level_nxt;

  function automatic logic [1:0] nxt_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Credit counts the word still in the memory pipe, so a push can never find the buffer full.
  assign r_en    = !arst && !empty && (({1'b0, occ} + {2'b0, inflight}) < 3'd3);
  assign m_valid = !arst && (occ != 2'd0);
  assign m_data  = buf_q[head];
  assign push    = inflight;
  assign pop     = m_valid && m_ready;

  always_ff @(posedge clk_r) begin
    if (arst) begin
      occ      <= 2'd0;
      head     <= 2'd0;
      tail     <= 2'd0;
      inflight <= 1'b0;
      buf_q    <= '0;
    end else begin
      inflight <= r_en;
      if (push) begin
        buf_q[tail] <= r_data;
        tail        <= nxt_idx(tail);
      end
      if (pop) head <= nxt_idx(head);
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Gray to binary: each bit is the XOR of all Gray bits at and above it.
  always_comb begin
    bin_wptr[PTR_WIDTH] = g_wptr_sync[PTR_WIDTH];
    for (int i = PTR_WIDTH - 1; i >= 0; i--)
      bin_wptr[i] = bin_wptr[i+1] ^ g_wptr_sync[i];
  end

  assign level_nxt = bin_wptr - b_rptr;

  always_ff @(posedge clk_r) begin
    if (arst) begin
      rd_level     <= '0;
      almost_empty <= 1'b1;
    end else begin
      rd_level     <= level_nxt;
      almost_empty <= (level_nxt <= AE_TH);
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk_r) begin
    if (arst)     cnt_q <= 16'd0;
    else if (pop) cnt_q <= cnt_q + 16'd1;
  end

  assign rd_count = cnt_q;
`else
  assign rd_count = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural FIFO memory/pointer source.
module tb_fifo_rd_stream;

`ifdef FIFO_RD_STREAM_CNT_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  logic       clk_r = 1'b0;
  logic       arst;
  logic       empty;
  logic [3:0] g_wptr_sync, b_rptr;
  logic       r_en;
  logic [7:0] r_data;
  logic       m_valid, m_ready;
  logic [7:0] m_data;
  logic [3:0] rd_level;
  logic       almost_empty;
  logic [15:0] rd_count;

  fifo_rd_stream #(.DATA_WIDTH(8), .PTR_WIDTH(3), .AEMPTY_THRESH(1)) dut (
    .clk_r(clk_r), .arst(arst), .empty(empty), .g_wptr_sync(g_wptr_sync),
    .b_rptr(b_rptr), .r_en(r_en), .r_data(r_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .rd_level(rd_level),
    .almost_empty(almost_empty), .rd_count(rd_count)
  );

  always #5 clk_r = ~clk_r;

  // Source memory: words written by the tasks, read one cycle after an accepted r_en.
  logic [7:0] mem [0:255];
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  assign empty = (wr_cnt == rd_cnt);

  always @(posedge clk_r) begin
    if (r_en && !empty) begin
      r_data <= mem[rd_cnt[7:0]];
      rd_cnt <= rd_cnt + 1;
    end
  end

  bit ovf_seen = 1'b0;
  always @(posedge clk_r)
    if (!arst && dut.inflight && dut.occ == 2'd3) ovf_seen <= 1'b1;

  int         nvec = 0;
  int         nerr = 0;
  int         ren_cnt = 0;
  logic [7:0] got_q[$];

  task automatic tick();
    #1;
    if (m_valid && m_ready) got_q.push_back(m_data);
    if (r_en && !empty) ren_cnt++;
    @(posedge clk_r);
    @(negedge clk_r);
  endtask

  task automatic write_word(input logic [7:0] d);
    mem[wr_cnt[7:0]] = d;
    wr_cnt = wr_cnt + 1;
  endtask

  task automatic test_reset();
    arst = 1'b1; m_ready = 1'b0; g_wptr_sync = 4'd0; b_rptr = 4'd0;
    @(negedge clk_r); #1;
    nvec++; if (r_en !== 1'b0) begin nerr++; $display("FAIL rst_ren: got %b exp 0", r_en); end
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL rst_mvalid: got %b exp 0", m_valid); end
    tick(); tick();
    arst = 1'b0; #1;
    nvec++; if (rd_level !== 4'd0) begin nerr++; $display("FAIL rst_level: got %0d exp 0", rd_level); end
    nvec++; if (almost_empty !== 1'b1) begin nerr++; $display("FAIL rst_aempty: got %b exp 1", almost_empty); end
    nvec++; if (m_data !== 8'h00) begin nerr++; $display("FAIL rst_mdata: got %h exp 00", m_data); end
    nvec++; if (rd_count !== 16'd0) begin nerr++; $display("FAIL rst_count: got %0d exp 0", rd_count); end
    nvec++; if (r_en !== 1'b0) begin nerr++; $display("FAIL idle_ren: got %b exp 0", r_en); end
    tick();
  endtask

  task automatic test_single();
    m_ready = 1'b1;
    write_word(8'hA5); #1;
    nvec++; if (r_en !== 1'b1) begin nerr++; $display("FAIL single_ren_n: got %b exp 1", r_en); end
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL single_mv_n: got %b exp 0", m_valid); end
    tick(); #1;
    nvec++; if (r_en !== 1'b0) begin nerr++; $display("FAIL single_ren_n1: got %b exp 0", r_en); end
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL single_mv_n1: got %b exp 0", m_valid); end
    tick(); #1;
    nvec++; if (m_valid !== 1'b1) begin nerr++; $display("FAIL single_mv_n2: got %b exp 1", m_valid); end
    nvec++; if (m_data !== 8'hA5) begin nerr++; $display("FAIL single_data: got %h exp a5", m_data); end
    tick(); #1;
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL single_mv_n3: got %b exp 0", m_valid); end
    nvec++; if (rd_count !== (CNT ? 16'd1 : 16'd0)) begin nerr++; $display("FAIL single_count: got %0d exp %0d", rd_count, CNT ? 1 : 0); end
  endtask

  task automatic test_stream();
    int first = -1;
    int last  = -1;
    int nval  = 0;
    got_q.delete();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) write_word(8'(i));
    for (int c = 0; c < 12; c++) begin
      #1;
      if (m_valid) begin
        if (first < 0) first = c;
        last = c;
        nval++;
      end
      tick();
    end
    nvec++; if (first !== 2) begin nerr++; $display("FAIL stream_first: got %0d exp 2", first); end
    nvec++; if (last !== 9) begin nerr++; $display("FAIL stream_last: got %0d exp 9", last); end
    nvec++; if (nval !== 8) begin nerr++; $display("FAIL stream_nvalid: got %0d exp 8", nval); end
    nvec++; if (got_q.size() !== 8) begin nerr++; $display("FAIL stream_size: got %0d exp 8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      nvec++;
      if (got_q[i] !== 8'(i)) begin nerr++; $display("FAIL stream_data[%0d]: got %h exp %h", i, got_q[i], 8'(i)); end
    end
    nvec++; if (rd_count !== (CNT ? 16'd9 : 16'd0)) begin nerr++; $display("FAIL stream_count: got %0d exp %0d", rd_count, CNT ? 9 : 0); end
  endtask

  task automatic test_backpressure();
    got_q.delete();
    ren_cnt = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) write_word(8'h10 + 8'(i));
    for (int c = 0; c < 6; c++) tick();
    #1;
    nvec++; if (ren_cnt !== 3) begin nerr++; $display("FAIL bp_reads: got %0d exp 3", ren_cnt); end
    nvec++; if (r_en !== 1'b0) begin nerr++; $display("FAIL bp_ren_stall: got %b exp 0", r_en); end
    nvec++; if (m_data !== 8'h10) begin nerr++; $display("FAIL bp_head: got %h exp 10", m_data); end
    m_ready = 1'b1; #1;
    nvec++; if (r_en !== 1'b0) begin nerr++; $display("FAIL bp_ren_pop: got %b exp 0", r_en); end
    tick(); #1;
    nvec++; if (r_en !== 1'b1) begin nerr++; $display("FAIL bp_ren_resume: got %b exp 1", r_en); end
    for (int c = 0; c < 8; c++) tick();
    nvec++; if (ren_cnt !== 6) begin nerr++; $display("FAIL bp_total_reads: got %0d exp 6", ren_cnt); end
    nvec++; if (got_q.size() !== 6) begin nerr++; $display("FAIL bp_size: got %0d exp 6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      nvec++;
      if (got_q[i] !== 8'h10 + 8'(i)) begin nerr++; $display("FAIL bp_data[%0d]: got %h exp %h", i, got_q[i], 8'h10 + 8'(i)); end
    end
    nvec++; if (ovf_seen !== 1'b0) begin nerr++; $display("FAIL bp_overflow: got %b exp 0", ovf_seen); end
    nvec++; if (rd_count !== (CNT ? 16'd15 : 16'd0)) begin nerr++; $display("FAIL bp_count: got %0d exp %0d", rd_count, CNT ? 15 : 0); end
  endtask

  task automatic test_level();
    b_rptr = 4'b1110; g_wptr_sync = 4'b0011; #1;
    nvec++; if (rd_level !== 4'd0) begin nerr++; $display("FAIL lvl_lag: got %0d exp 0", rd_level); end
    tick(); #1;
    nvec++; if (rd_level !== 4'd4) begin nerr++; $display("FAIL lvl_wrap: got %0d exp 4", rd_level); end
    nvec++; if (almost_empty !== 1'b0) begin nerr++; $display("FAIL lvl_wrap_ae: got %b exp 0", almost_empty); end
    b_rptr = 4'b0001;
    tick(); #1;
    nvec++; if (rd_level !== 4'd1) begin nerr++; $display("FAIL lvl_one: got %0d exp 1", rd_level); end
    nvec++; if (almost_empty !== 1'b1) begin nerr++; $display("FAIL lvl_one_ae: got %b exp 1", almost_empty); end
    b_rptr = 4'b0000;
    tick(); #1;
    nvec++; if (rd_level !== 4'd2) begin nerr++; $display("FAIL lvl_two: got %0d exp 2", rd_level); end
    nvec++; if (almost_empty !== 1'b0) begin nerr++; $display("FAIL lvl_two_ae: got %b exp 0", almost_empty); end
    g_wptr_sync = 4'b1100;
    tick(); #1;
    nvec++; if (rd_level !== 4'd8) begin nerr++; $display("FAIL lvl_full: got %0d exp 8", rd_level); end
    g_wptr_sync = 4'b0000;
    tick();
  endtask

  task automatic test_reset_midstream();
    got_q.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_word(8'h20 + 8'(i));
    for (int c = 0; c < 3; c++) tick();
    arst = 1'b1; #1;
    nvec++; if (r_en !== 1'b0) begin nerr++; $display("FAIL mid_ren_rst: got %b exp 0", r_en); end
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL mid_mv_rst: got %b exp 0", m_valid); end
    tick();
    arst = 1'b0; #1;
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL mid_mv_after: got %b exp 0", m_valid); end
    nvec++; if (rd_count !== 16'd0) begin nerr++; $display("FAIL mid_count: got %0d exp 0", rd_count); end
    nvec++; if (m_data !== 8'h00) begin nerr++; $display("FAIL mid_mdata: got %h exp 00", m_data); end
    m_ready = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    nvec++; if (got_q.size() !== 1) begin nerr++; $display("FAIL mid_size: got %0d exp 1", got_q.size()); end
    if (got_q.size() > 0) begin
      nvec++; if (got_q[0] !== 8'h23) begin nerr++; $display("FAIL mid_data: got %h exp 23", got_q[0]); end
    end
    nvec++; if (rd_count !== (CNT ? 16'd1 : 16'd0)) begin nerr++; $display("FAIL mid_count_post: got %0d exp %0d", rd_count, CNT ? 1 : 0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_level();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
